store_write_buffer: RTL and testbench

// - Posted-write FIFO between the data cache and data_mem; the data cache is write-through.
// - Absorbs CPU stores in 1 cycle and drains them to data_mem under a req/ack handshake.
// - Stalls the pipeline only when full.
// - Forwards buffered store data to cache line fills so a miss never reads stale memory.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_match.sv | 39 +++
 rtl/store_write_buffer.sv | 144 ++++++++++++++
 tb/tb_store_write_buffer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the store write buffer.
//   WB_AW / WB_DW / WB_DEPTH : default word-address width, data width, depth
//   ST_IDLE / ST_REQ / ST_GAP : drain FSM state encoding
//   wb_entry_t                : one buffered store {valid, addr, data}
package wb_pkg;

  localparam int WB_AW    = 11;
  localparam int WB_DW    = 32;
  localparam int WB_DEPTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef struct packed {
    logic              valid;
    logic [WB_AW-1:0]  addr;
    logic [WB_DW-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// wb_match: combinational address search over the buffer entries.
//   valid/addr : per-entry valid bits and addresses
//   head/tail  : ring pointers (tail = next free slot)
//   skip_head  : exclude the head slot from the search (head is in flight)
//   key        : address to look up
//   hit/idx    : a valid entry matches; idx is the youngest such entry
module wb_match #(
  parameter int DEPTH = 4,
  parameter int AW    = 11,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]         valid,
  input  logic [DEPTH-1:0][AW-1:0] addr,
  input  logic [PW-1:0]            head,
  input  logic [PW-1:0]            tail,
  input  logic                     skip_head,
  input  logic [AW-1:0]            key,
  output logic                     hit,
  output logic [PW-1:0]            idx
);

  logic [PW-1:0] pos;

  // Walk from tail-1 backwards (youngest first); the first match wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pos = tail - PW'(k + 1);
      if (!hit && valid[pos] && (addr[pos] == key) &&
          !(skip_head && (pos == head))) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// store_write_buffer: posted-write FIFO between a write-through data cache
// and data_mem.
//   clk, rst (async, active-low)
//   st_en/st_addr/st_data/st_ready : store port from MEM stage (stall when !st_ready)
//   ld_addr/fwd_hit/fwd_data       : forwarding lookup for cache line fills
//   mem_req/mem_addr/mem_data/mem_ack : write port to data_mem
//   flush : stop accepting stores, keep draining; empty : nothing buffered/in flight
//   dbg_state : drain FSM state
//
// Handshake: a store transfers on a cycle with st_en=1 and st_ready=1. A
// memory write is offered while mem_req=1 with mem_addr/mem_data frozen and
// completes on the first cycle with mem_ack=1; mem_ack is ignored otherwise.
module store_write_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_en,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  output logic          st_ready,
  input  logic [AW-1:0] ld_addr,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  input  logic          mem_ack,
  input  logic          flush,
  output logic          empty,
  output logic [1:0]    dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]         valid_q;
  logic [DEPTH-1:0][AW-1:0] addr_q;
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [PW-1:0]            head_q;
  logic [PW-1:0]            tail_q;
  logic [CW-1:0]            count_q;
  logic [1:0]               state_q;

  logic          coal_hit;
  logic [PW-1:0] coal_idx;
  logic [PW-1:0] fwd_idx;
  logic          head_locked;
  logic          do_coal;
  logic          do_push;
  logic          pop;

  // The head is committed to memory from the cycle it gets latched (IDLE with
  // entries) until it is popped; coalescing into it would lose the update.
  assign head_locked = (state_q != ST_GAP);

  wb_match #(.DEPTH(DEPTH), .AW(AW)) u_coal_match (
    .valid     (valid_q),
    .addr      (addr_q),
    .head      (head_q),
    .tail      (tail_q),
    .skip_head (head_locked),
    .key       (st_addr),
    .hit       (coal_hit),
    .idx       (coal_idx)
  );

  wb_match #(.DEPTH(DEPTH), .AW(AW)) u_fwd_match (
    .valid     (valid_q),
    .addr      (addr_q),
    .head      (head_q),
    .tail      (tail_q),
    .skip_head (1'b0),
    .key       (ld_addr),
    .hit       (fwd_hit),
    .idx       (fwd_idx)
  );

  // Readiness uses the pre-pop count, so a same-cycle pop never frees a slot.
  assign st_ready  = !flush && ((count_q < CW'(DEPTH)) || coal_hit);
  assign do_coal   = st_en && st_ready && coal_hit;
  assign do_push   = st_en && st_ready && !coal_hit;
  assign pop       = (state_q == ST_REQ) && mem_ack;
  assign mem_req   = (state_q == ST_REQ);
  assign empty     = (count_q == '0) && (state_q == ST_IDLE);
  assign fwd_data  = fwd_hit ? data_q[fwd_idx] : '0;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (do_coal) begin
        data_q[coal_idx] <= st_data;
      end
      // Push slot is free (count<DEPTH), so it never collides with the pop.
      if (do_push) begin
        valid_q[tail_q] <= 1'b1;
        addr_q[tail_q]  <= st_addr;
        data_q[tail_q]  <= st_data;
        tail_q          <= tail_q + PW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(pop);

      case (state_q)
        ST_IDLE: begin
          if (count_q != '0) begin
            mem_addr <= addr_q[head_q];
            mem_data <= data_q[head_q];
            state_q  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ack) state_q <= ST_GAP;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(pop && (count_q == '0)));
      assert (!(do_push && (count_q == CW'(DEPTH))));
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: directed + random checks of store_write_buffer
// against a queue-based model of the buffer contents.
module tb_store_write_buffer;
  import wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 11;
  localparam int DW    = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          st_en;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic [AW-1:0] ld_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_ack;
  logic          flush;
  logic          empty;
  logic [1:0]    dbg_state;

  store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_en     (st_en),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_ready  (st_ready),
    .ld_addr   (ld_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ack   (mem_ack),
    .flush     (flush),
    .empty     (empty),
    .dbg_state (dbg_state)
  );

  // ---------------- model / scoreboard ----------------
  wb_entry_t        buf_q[$];       // oldest at index 0
  logic [AW+DW-1:0] exp_q[$];       // expected memory writes, in order
  int               phase;          // 0 idle, 1 requesting, 2 settle gap
  logic [AW-1:0]    lat_addr;
  logic [DW-1:0]    lat_data;
  logic [DW-1:0]    dmem [0:2047];  // what data_mem received
  int               n_writes;
  int               n_checks;
  int               n_errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic int find_young(input logic [AW-1:0] a, input bit skip_head);
    for (int i = buf_q.size() - 1; i >= 0; i--)
      if (buf_q[i].addr == a && !(skip_head && i == 0)) return i;
    return -1;
  endfunction

  task automatic model_reset();
    buf_q.delete();
    exp_q.delete();
    phase    = 0;
    lat_addr = '0;
    lat_data = '0;
  endtask

  // One clock: check outputs at the falling edge, then advance the model
  // across the rising edge. Returns 1 ns after the rising edge.
  task automatic cycle();
    int  ci;
    int  fi;
    int  size_before;
    bit  rdy;
    bit  in_reset;
    logic [AW+DW-1:0] w;
    @(negedge clk);
    in_reset = !rst;
    ci = -1;
    rdy = 1'b0;
    size_before = 0;
    if (in_reset) begin
      model_reset();
      chk("rst_mem_req", mem_req, 0);
      chk("rst_empty", empty, 1);
      chk("rst_st_ready", st_ready, !flush);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_data", mem_data, 0);
      chk("rst_count", dut.count_q, 0);
    end else begin
      size_before = buf_q.size();
      ci  = find_young(st_addr, phase != 2);
      rdy = !flush && (size_before < DEPTH || ci >= 0);
      chk("st_ready", st_ready, rdy);
      chk("mem_req", mem_req, phase == 1);
      if (phase == 1) begin
        chk("mem_addr", mem_addr, lat_addr);
        chk("mem_data", mem_data, lat_data);
      end
      fi = find_young(ld_addr, 1'b0);
      chk("fwd_hit", fwd_hit, fi >= 0);
      chk("fwd_data", fwd_data, (fi >= 0) ? buf_q[fi].data : 32'h0);
      chk("empty", empty, size_before == 0 && phase == 0);
      chk("count", dut.count_q, size_before);
      if (phase == 1 && mem_ack) exp_q.push_back({lat_addr, lat_data});
      if (mem_req && mem_ack) begin
        n_writes++;
        dmem[mem_addr] = mem_data;
        chk("write_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          chk("write", {mem_addr, mem_data}, w);
        end
      end
    end
    @(posedge clk);
    if (!in_reset) begin
      if (st_en && rdy) begin
        if (ci >= 0) buf_q[ci].data = st_data;
        else buf_q.push_back('{1'b1, st_addr, st_data});
      end
      case (phase)
        0: if (size_before > 0) begin
             lat_addr = buf_q[0].addr;
             lat_data = buf_q[0].data;
             phase = 1;
           end
        1: if (mem_ack) begin
             void'(buf_q.pop_front());
             phase = 2;
           end
        default: phase = 0;
      endcase
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b0; st_en = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    cycle(); cycle();
    rst = 1'b1;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    st_en = 1'b1; st_addr = a; st_data = d;
    cycle();
    st_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    st_en = 1'b0; mem_ack = 1'b1;
    for (int k = 0; k < 60 && !empty; k++) cycle();
    chk(tag, empty, 1);
    mem_ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    n_checks = 0; n_errors = 0; n_writes = 0;
    for (int i = 0; i < 2048; i++) dmem[i] = '0;
    model_reset();
    rst = 1'b0; st_en = 1'b1; st_addr = 11'h100; st_data = 32'h0BAD0BAD;
    ld_addr = '0; mem_ack = 1'b0; flush = 1'b0;

    // Reset held 3 cycles with a store pending, then first store accepted.
    repeat (3) cycle();
    rst = 1'b1;
    #1 chk("reset_release_ready", st_ready, 1);
    cycle();
    st_en = 1'b0;
    #1 chk("first_store_count", dut.count_q, 1);
    drain("drain_first");

    // Fill and stall with mem_ack held low.
    do_reset();
    for (int i = 0; i < 4; i++) store(11'h010 + 11'(i), 32'hF000_0000 + 32'(i));
    st_en = 1'b1; st_addr = 11'h014; st_data = 32'hF000_0004;
    #1 chk("full_stall", st_ready, 0);
    chk("head_held", mem_addr, 11'h010);
    cycle();
    mem_ack = 1'b1;
    #1 chk("pop_cycle_stall", st_ready, 0);
    cycle();
    mem_ack = 1'b0;
    #1 chk("after_pop_ready", st_ready, 1);
    cycle();
    st_en = 1'b0;
    drain("drain_fill");
    chk("fill_mem_014", dmem[11'h014], 32'hF000_0004);

    // Coalesce while the head is in flight.
    do_reset();
    store(11'h010, 32'h1111_0000);
    store(11'h020, 32'hAAAA_0001);
    store(11'h020, 32'hBBBB_0002);
    cycle();
    #1 chk("coal_count", dut.count_q, 2);
    drain("drain_coal");
    chk("coal_mem_020", dmem[11'h020], 32'hBBBB_0002);

    // Forwarding visibility and miss.
    do_reset();
    mem_ack = 1'b0;
    ld_addr = 11'h7F3;
    st_en = 1'b1; st_addr = 11'h7F3; st_data = 32'h1234_5678;
    #1 chk("fwd_same_cycle", fwd_hit, 0);
    cycle();
    st_en = 1'b0;
    #1 chk("fwd_hit_next", fwd_hit, 1);
    chk("fwd_data_next", fwd_data, 32'h1234_5678);
    ld_addr = 11'h7F4;
    #1 chk("fwd_miss_hit", fwd_hit, 0);
    chk("fwd_miss_data", fwd_data, 0);
    drain("drain_fwd");

    // Store to the in-flight head address pushes a new entry.
    do_reset();
    store(11'h010, 32'hCAFE_0001);
    cycle();
    store(11'h010, 32'hCAFE_0002);
    #1 chk("headmatch_count", dut.count_q, 2);
    base = n_writes;
    drain("drain_headmatch");
    chk("headmatch_writes", n_writes - base, 2);
    chk("headmatch_final", dmem[11'h010], 32'hCAFE_0002);

    // Flush drains three stores and refuses new ones.
    do_reset();
    for (int i = 1; i <= 3; i++) store(11'(i), 32'hD000_0000 + 32'(i));
    flush = 1'b1;
    st_en = 1'b1; st_addr = 11'h004; st_data = 32'hDEAD_0004;
    #1 chk("flush_refuse", st_ready, 0);
    base = n_writes;
    mem_ack = 1'b1;
    for (int k = 0; k < 60 && !empty; k++) cycle();
    chk("flush_empty", empty, 1);
    chk("flush_writes", n_writes - base, 3);
    st_en = 1'b0; mem_ack = 1'b0; flush = 1'b0;

    // Flush again, async reset while requesting.
    do_reset();
    for (int i = 1; i <= 3; i++) store(11'(i), 32'hE000_0000 + 32'(i));
    flush = 1'b1;
    for (int k = 0; k < 10 && !mem_req; k++) cycle();
    chk("req_up", mem_req, 1);
    rst = 1'b0;
    #1 chk("async_req_drop", mem_req, 0);
    chk("async_empty", empty, 1);
    cycle();
    flush = 1'b0;
    rst = 1'b1;
    cycle();

    // Random traffic with a small address pool to provoke coalescing.
    do_reset();
    for (int n = 0; n < 500; n++) begin
      st_en   = 1'($urandom_range(0, 1));
      st_addr = 11'($urandom_range(0, 7));
      st_data = $urandom;
      ld_addr = 11'($urandom_range(0, 9));
      mem_ack = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 15) == 0);
      cycle();
    end
    flush = 1'b0;
    drain("drain_random");
    chk("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
